// File: rtl/timebase_ctrl.sv
// Timebase controller: owns the divider count and sequences each change (wait for idle, hold, apply, settle).
// Optional acq_busy watchdog enabled by defining TB_WATCHDOG_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | accepting host/panel requests, div_count settled
// S_WAIT   | change pending, acq_hold high, waiting for acq_busy to drop
// S_APPLY  | one cycle: new count driven to the divider
// S_SETTLE | divider re-syncing after count change, tb_ready low
module timebase_ctrl #(
    parameter int unsigned CW          = 16,
    parameter int unsigned MAX_COUNT   = 32'h8000,
    parameter int unsigned RESET_COUNT = 0,
    parameter int unsigned SETTLE      = 64,
    parameter int unsigned WDOG        = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_valid,
    input  logic [CW-1:0] host_count,
    output logic          host_ready,
    input  logic          panel_up,
    input  logic          panel_dn,
    input  logic          acq_busy,
    output logic          acq_hold,
    output logic [CW-1:0] div_count,
    output logic          tb_ready,
    output logic          busy,
    output logic          wdog_err
);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_COUNT);
    localparam logic [CW-1:0] RESET_C = CW'(RESET_COUNT);
    localparam int unsigned   SW      = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY, S_SETTLE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tgt;
    logic [SW-1:0] settle_cnt;
    logic          pend_valid, pend_up;

    logic          host_xfer, panel_new, step_any, step_up;
    logic          req_valid, req_change;
    logic [CW:0]   dbl;
    logic [CW-1:0] req_count;
    logic          wdog_fire;

`ifdef TB_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG + 1);
    logic [WW-1:0] wdog_cnt;
    logic          wdog_err_q;

    assign wdog_fire = acq_busy && (wdog_cnt == '0);
    assign wdog_err  = wdog_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt   <= WW'(WDOG - 1);
            wdog_err_q <= 1'b0;
        end else if (state == S_IDLE) begin
            wdog_cnt <= WW'(WDOG - 1);
        end else if (state == S_WAIT && acq_busy) begin
            if (wdog_cnt == '0) begin
                wdog_err_q <= 1'b1;
            end else begin
                wdog_cnt <= wdog_cnt - 1'b1;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    // Request target; up/down steps are relative to the count currently on the divider.
    always_comb begin
        host_xfer = host_valid && (state == S_IDLE);
        panel_new = panel_up ^ panel_dn;
        step_any  = panel_new || pend_valid;
        step_up   = panel_new ? panel_up : pend_up;
        dbl       = {div_count, 1'b0};
        req_valid = 1'b0;
        req_count = div_count;
        if (host_xfer) begin
            req_valid = 1'b1;
            req_count = (host_count > MAX_C) ? MAX_C : host_count;
        end else if (step_any) begin
            req_valid = 1'b1;
            if (step_up) begin
                if (div_count == '0) begin
                    req_count = CW'(1);
                end else begin
                    req_count = (dbl > {1'b0, MAX_C}) ? MAX_C : dbl[CW-1:0];
                end
            end else begin
                req_count = div_count >> 1;
            end
        end
        req_change = req_valid && (req_count != div_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_change) state_nxt = S_WAIT;
            S_WAIT:   if (!acq_busy || wdog_fire) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        host_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_count  <= RESET_C;
            tgt        <= RESET_C;
            acq_hold   <= 1'b0;
            tb_ready   <= 1'b0;
            settle_cnt <= SW'(SETTLE - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_change) begin
                        tgt      <= req_count;
                        acq_hold <= 1'b1;
                    end
                end
                S_APPLY: begin
                    div_count  <= tgt;
                    tb_ready   <= 1'b0;
                    settle_cnt <= SW'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        tb_ready <= 1'b1;
                        acq_hold <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A step is consumed by any IDLE cycle without a host transfer; otherwise the last pulse wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_up    <= 1'b0;
        end else if (state == S_IDLE && !host_xfer) begin
            pend_valid <= 1'b0;
        end else if (panel_new) begin
            pend_valid <= 1'b1;
            pend_up    <= panel_up;
        end
    end
endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: expected settled counts are queued by the stimulus and checked on each tb_ready rise.
module tb_timebase_ctrl;
    localparam int SETTLE = 64;
    localparam int WDOG   = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid = 1'b0;
    logic [15:0] host_count = 16'd0;
    logic        panel_up = 1'b0;
    logic        panel_dn = 1'b0;
    logic        acq_busy = 1'b0;
    logic        host_ready, acq_hold, tb_ready, busy, wdog_err;
    logic [15:0] div_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    timebase_ctrl #(
        .CW(16), .MAX_COUNT(32'h8000), .RESET_COUNT(0), .SETTLE(SETTLE), .WDOG(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_count(host_count),
        .host_ready(host_ready), .panel_up(panel_up), .panel_dn(panel_dn),
        .acq_busy(acq_busy), .acq_hold(acq_hold), .div_count(div_count),
        .tb_ready(tb_ready), .busy(busy), .wdog_err(wdog_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input int val);
        int k;
        host_valid = 1'b1;
        host_count = 16'(val);
        k = 0;
        while (!host_ready && k < 2000) begin
            tick();
            k++;
        end
        chk("host_ready_wait", int'(host_ready), 1);
        tick();
        host_valid = 1'b0;
    endtask

    task automatic pulse(input logic up, input logic dn);
        panel_up = up;
        panel_dn = dn;
        tick();
        panel_up = 1'b0;
        panel_dn = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && tb_ready && !busy) && k < 6000) begin
            tick();
            k++;
        end
        chk(name, int'(k < 6000), 1);
    endtask

    task automatic wait_low(input string name);
        int k;
        k = 0;
        while (tb_ready && k < 200) begin
            tick();
            k++;
        end
        chk(name, int'(tb_ready), 0);
    endtask

    task automatic expect_quiet(input string name, input int cnt);
        int seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) seen = 1;
        end
        chk({name, "_busy"}, seen, 0);
        chk({name, "_count"}, int'(div_count), cnt);
    endtask

    // Monitor: every tb_ready rise must match the next queued count after exactly SETTLE low cycles.
    int   cyc = 0;
    int   fall_cyc = 0;
    logic prev_rdy = 1'b1;
    initial begin
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_rdy = 1'b1;
            end else begin
                if (!tb_ready && prev_rdy) fall_cyc = cyc;
                if (tb_ready && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_settle", int'(div_count), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("settle_count", int'(div_count), e);
                        chk("settle_len", cyc - fall_cyc, SETTLE);
                        chk("settle_hold_drop", int'(acq_hold), 0);
                    end
                end
                prev_rdy = tb_ready;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // 1: reset values and post-reset settle
        tick();
        tick();
        chk("rst_div_count", int'(div_count), 0);
        chk("rst_acq_hold", int'(acq_hold), 0);
        chk("rst_host_ready", int'(host_ready), 0);
        chk("rst_tb_ready", int'(tb_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_wdog_err", int'(wdog_err), 0);
        exp_q.push_back(0);
        rst_n = 1'b1;
        wait_done("reset_settle_done");

        // 2: host request 100, latency and hold window
        exp_q.push_back(100);
        host_req(100);
        tick();
        chk("h100_hold_n1", int'(acq_hold), 1);
        chk("h100_count_n1", int'(div_count), 0);
        chk("h100_busy_n1", int'(busy), 1);
        chk("h100_ready_n1", int'(host_ready), 0);
        chk("h100_tbready_n1", int'(tb_ready), 1);
        tick();
        chk("h100_count_n2", int'(div_count), 100);
        chk("h100_tbready_n2", int'(tb_ready), 0);
        chk("h100_hold_n2", int'(acq_hold), 1);
        wait_done("h100_done");
        chk("h100_hold_after", int'(acq_hold), 0);
        exp_q.push_back(0);
        host_req(0);
        wait_done("h0_done");

        // 3: panel steps up 1,2,4 then down 2,1,0, then floor
        exp_q.push_back(1); pulse(1'b1, 1'b0); wait_done("up1");
        exp_q.push_back(2); pulse(1'b1, 1'b0); wait_done("up2");
        exp_q.push_back(4); pulse(1'b1, 1'b0); wait_done("up4");
        exp_q.push_back(2); pulse(1'b0, 1'b1); wait_done("dn2");
        exp_q.push_back(1); pulse(1'b0, 1'b1); wait_done("dn1");
        exp_q.push_back(0); pulse(1'b0, 1'b1); wait_done("dn0");
        pulse(1'b0, 1'b1);
        expect_quiet("dn_floor", 0);

        // 4: acq_busy blocks the change; clamp to MAX_COUNT
        acq_busy = 1'b1;
        exp_q.push_back(32'h8000);
        host_req(32'h9000);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (i % 100 == 50) begin
                chk("busywait_hold", int'(acq_hold), 1);
                chk("busywait_count", int'(div_count), 0);
            end
        end
        acq_busy = 1'b0;
        tick();
        chk("busyfall_count_m", int'(div_count), 0);
        tick();
        chk("busyfall_count_m1", int'(div_count), 32'h8000);
        wait_done("clamp_done");
        pulse(1'b1, 1'b0);
        expect_quiet("up_clamp", 32'h8000);

        // 5: backpressure, pending step (last pulse wins), simultaneous up+dn, host over panel
        exp_q.push_back(16);
        exp_q.push_back(8);
        host_req(16);
        host_valid = 1'b1;
        host_count = 16'h0077;
        chk("backpressure_ready", int'(host_ready), 0);
        host_valid = 1'b0;
        wait_low("pend_settle_low");
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        wait_done("pend_done");
        chk("pend_dn_count", int'(div_count), 8);
        pulse(1'b1, 1'b1);
        expect_quiet("updn_same", 8);
        host_valid = 1'b1;
        host_count = 16'd20;
        panel_up   = 1'b1;
        chk("hostpanel_ready", int'(host_ready), 1);
        exp_q.push_back(20);
        exp_q.push_back(40);
        tick();
        host_valid = 1'b0;
        panel_up   = 1'b0;
        wait_done("hostpanel_done");
        chk("hostpanel_count", int'(div_count), 40);

`ifdef TB_WATCHDOG_EN
        chk("wdog_err_before", int'(wdog_err), 0);
        acq_busy = 1'b1;
        exp_q.push_back(5);
        host_req(5);
        k = 0;
        while (div_count != 16'd5 && k < 6000) begin
            tick();
            k++;
        end
        chk("wdog_apply_cycle", k, WDOG + 1);
        chk("wdog_err_set", int'(wdog_err), 1);
        acq_busy = 1'b0;
        wait_done("wdog_done");
        chk("wdog_err_sticky", int'(wdog_err), 1);
`else
        k = 0;
        chk("wdog_err_tied", int'(wdog_err), k);
`endif

        // 6: reset during SETTLE aborts everything
        exp_q.push_back(0);
        host_req(32'h55);
        wait_low("midrst_settle_low");
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_count", int'(div_count), 0);
        chk("midrst_hold", int'(acq_hold), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_wdog", int'(wdog_err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_done("midrst_done");
        chk("midrst_final_count", int'(div_count), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
